// File: rtl/hamming_decode_engine.sv
// SECDED decoder that walks encoded 16-bit words in data memory, corrects single errors,
// flags double errors and writes each 11-bit message with a 2-bit status back to memory.
module hamming_decode_engine #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  output logic [3:0] n_single,
  output logic [3:0] n_double
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CAP_HI, WR_LO, WR_HI, DONE} state_t;

  localparam logic [7:0] SRC8     = 8'(SRC_BASE);
  localparam logic [7:0] DST8     = 8'(DST_BASE);
  localparam logic [6:0] LAST_IDX = 7'(NUM_WORDS - 1);

  // Bit b of the syndrome covers every Hamming position whose index has bit b set.
  function automatic logic [15:0] syn_mask(input int b);
    logic [15:0] m;
    m = '0;
    for (int k = 1; k < 16; k++) m[k] = ((k >> b) & 1) == 1;
    return m;
  endfunction

  state_t      state_reg, state_next;
  logic [6:0]  idx_reg;
  logic [7:0]  lo_reg;
  logic [10:0] msg_reg;
  logic [1:0]  status_reg;
  logic [3:0]  n_single_reg, n_double_reg;

  logic [15:0] word;
  logic [3:0]  syndrome;
  logic        parity;
  logic        dbl_err;
  logic [10:0] msg;
  logic [7:0]  idx2;

  // The high byte arrives on the read port in CAP_HI; decode straight from it.
  assign word    = {mem_rd_data, lo_reg};
  assign parity  = ^word;
  assign dbl_err = ~parity & (syndrome != 4'd0);
  assign idx2    = {idx_reg, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_syn
      localparam logic [15:0] MASK = syn_mask(gi);
      assign syndrome[gi] = ^(word & MASK);
    end
    // Message bit gi sits at Hamming position POS; flip it when it is the single-error site.
    for (gi = 0; gi < 11; gi++) begin : g_msg
      localparam int POS = (gi == 0) ? 3 : (gi < 4) ? gi + 4 : gi + 5;
      assign msg[gi] = word[POS] ^ (parity && (syndrome == 4'(POS)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      lo_reg       <= '0;
      msg_reg      <= '0;
      status_reg   <= '0;
      n_single_reg <= '0;
      n_double_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            idx_reg      <= '0;
            n_single_reg <= '0;
            n_double_reg <= '0;
          end
        end
        RD_HI: lo_reg <= mem_rd_data;
        CAP_HI: begin
          msg_reg    <= msg;
          status_reg <= {dbl_err, parity};
          if (parity && n_single_reg != 4'hF) n_single_reg <= n_single_reg + 4'd1;
          if (dbl_err && n_double_reg != 4'hF) n_double_reg <= n_double_reg + 4'd1;
        end
        WR_HI: if (idx_reg != LAST_IDX) idx_reg <= idx_reg + 7'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next  = state_reg;
    mem_addr    = 8'd0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'd0;
    case (state_reg)
      IDLE, DONE: if (start) state_next = RD_LO;
      RD_LO: begin
        mem_addr   = SRC8 + idx2;
        state_next = RD_HI;
      end
      RD_HI: begin
        mem_addr   = SRC8 + idx2 + 8'd1;
        state_next = CAP_HI;
      end
      CAP_HI: state_next = WR_LO;
      WR_LO: begin
        mem_wr_en   = 1'b1;
        mem_addr    = DST8 + idx2;
        mem_wr_data = msg_reg[7:0];
        state_next  = WR_HI;
      end
      WR_HI: begin
        mem_wr_en   = 1'b1;
        mem_addr    = DST8 + idx2 + 8'd1;
        mem_wr_data = {status_reg, 3'b000, msg_reg[10:8]};
        state_next  = (idx_reg == LAST_IDX) ? DONE : RD_LO;
      end
      default: state_next = IDLE;
    endcase
  end

  assign done     = (state_reg == DONE);
  assign n_single = n_single_reg;
  assign n_double = n_double_reg;

endmodule
